innings_sequencer: RTL and testbench

//  Match-flow master that produces the delivery stream consumed by the LED ball counter and score displays.

---
 rtl/cricket_pkg.sv | 48 ++++
 rtl/bowl_edge_detect.sv | 27 ++
 rtl/innings_sequencer.sv | 148 ++++++++++++++
 tb/tb_innings_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cricket_pkg.sv
// Shared match definitions: outcome codes, per-code scoring, sequencer states and winner codes.
package cricket_pkg;

  localparam logic [3:0] OUT_DOT_A  = 4'd0;
  localparam logic [3:0] OUT_DOT_B  = 4'd1;
  localparam logic [3:0] OUT_SIX    = 4'd10;
  localparam logic [3:0] OUT_WKT_A  = 4'd11;
  localparam logic [3:0] OUT_WKT_B  = 4'd12;
  localparam logic [3:0] OUT_WIDE   = 4'd13;
  localparam logic [3:0] OUT_NOBALL = 4'd14;
  localparam logic [3:0] OUT_DOT_C  = 4'd15;

  typedef enum logic [1:0] {
    INN1  = 2'd0,
    BREAK = 2'd1,
    INN2  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_TEAM1 = 2'b01;
  localparam logic [1:0] WIN_TEAM2 = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  function automatic logic [2:0] runs_for_code(input logic [3:0] code);
    logic [2:0] r;
    r = 3'd0;
    case (code)
      4'd2, 4'd3, 4'd4:       r = 3'd1;
      4'd5, 4'd6:             r = 3'd2;
      4'd7:                   r = 3'd3;
      4'd8, 4'd9:             r = 3'd4;
      OUT_SIX:                r = 3'd6;
      OUT_WIDE, OUT_NOBALL:   r = 3'd1;
      default:                r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic is_wicket_code(input logic [3:0] code);
    return (code == OUT_WKT_A) || (code == OUT_WKT_B);
  endfunction

  function automatic logic is_legal_code(input logic [3:0] code);
    return (code != OUT_WIDE) && (code != OUT_NOBALL);
  endfunction

endpackage

// File: rtl/bowl_edge_detect.sv
// Two-flop synchroniser for an asynchronous button level, followed by a one-cycle rising-edge pulse.
module bowl_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/innings_sequencer.sv
// Match-flow master: bowl presses become delivery pulses, scores are tallied, innings are sequenced.
// Optional build macro FREE_HIT_EN: a no-ball arms a free hit that turns the next legal wicket into a dot.
module innings_sequencer
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_INNING = 12,
  parameter int WICKETS_PER_SIDE = 3,
  parameter int RUN_W            = 8
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             bowl,
  input  logic [3:0]       lfsr_out,
  output logic             delivery,
  output logic [3:0]       outcome,
  output logic             teamSwitch,
  output logic             inningOver,
  output logic             gameOver,
  output logic [RUN_W-1:0] team1Runs,
  output logic [RUN_W-1:0] team2Runs,
  output logic [3:0]       wickets,
  output logic [1:0]       winner
);

  localparam logic [6:0] BALL_LIM = 7'(BALLS_PER_INNING);
  localparam logic [3:0] WKT_LIM  = 4'(WICKETS_PER_SIDE);

  state_t           state_q;
  state_t           state_d;
  logic [6:0]       ball_cnt;
  logic             rise;
  logic             accept;
  logic             in_innings;
  logic             legal;
  logic             wkt;
  logic [2:0]       add_runs;
  logic [RUN_W-1:0] bat_runs_n;
  logic [RUN_W-1:0] runs2_n;
  logic [3:0]       wk_n;
  logic [6:0]       balls_n;
  logic             innings_end;

  function automatic logic [RUN_W-1:0] sat_runs(input logic [RUN_W-1:0] r,
                                                input logic [2:0]       a);
    logic [RUN_W:0] s;
    s = {1'b0, r} + (RUN_W+1)'(a);
    return s[RUN_W] ? {RUN_W{1'b1}} : s[RUN_W-1:0];
  endfunction

  function automatic logic [3:0] sat_wkt(input logic [3:0] w, input logic inc);
    logic [3:0] r;
    r = w;
    if (inc && (w < WKT_LIM)) r = w + 4'd1;
    return r;
  endfunction

  bowl_edge_detect u_bowl_edge (
    .clk   (clk_fpga),
    .reset (reset),
    .btn   (bowl),
    .rise  (rise)
  );

  assign in_innings = (state_q == INN1) || (state_q == INN2);
  assign accept     = rise && !delivery && (state_q != DONE);

`ifdef FREE_HIT_EN
  logic free_hit;

  // Free hit survives wides, is consumed by the next legal ball, and never crosses an innings.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      free_hit <= 1'b0;
    end else if ((delivery && innings_end) || (state_q == BREAK && accept)) begin
      free_hit <= 1'b0;
    end else if (delivery) begin
      if (outcome == OUT_NOBALL) free_hit <= 1'b1;
      else if (legal)            free_hit <= 1'b0;
    end
  end

  assign wkt = is_wicket_code(outcome) && !free_hit;
`else
  assign wkt = is_wicket_code(outcome);
`endif

  // Post-update score view used both for the counters and the end-of-innings decision.
  always_comb begin
    add_runs    = runs_for_code(outcome);
    legal       = is_legal_code(outcome);
    bat_runs_n  = sat_runs((state_q == INN2) ? team2Runs : team1Runs, add_runs);
    runs2_n     = (state_q == INN2) ? bat_runs_n : team2Runs;
    wk_n        = sat_wkt(wickets, wkt);
    balls_n     = ball_cnt + 7'(legal);
    innings_end = (balls_n == BALL_LIM) || (wk_n == WKT_LIM) ||
                  ((state_q == INN2) && (runs2_n > team1Runs));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INN1:    if (delivery && innings_end) state_d = BREAK;
      BREAK:   if (accept) state_d = INN2;
      INN2:    if (delivery && innings_end) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = INN1;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q   <= INN1;
      delivery  <= 1'b0;
      outcome   <= 4'd0;
      team1Runs <= '0;
      team2Runs <= '0;
      wickets   <= 4'd0;
      ball_cnt  <= 7'd0;
    end else begin
      state_q  <= state_d;
      delivery <= accept && in_innings;
      if (accept && in_innings) outcome <= lfsr_out;
      if (delivery) begin
        if (state_q == INN2) team2Runs <= bat_runs_n;
        else                 team1Runs <= bat_runs_n;
        wickets  <= wk_n;
        ball_cnt <= balls_n;
      end else if (state_q == BREAK && accept) begin
        wickets  <= 4'd0;
        ball_cnt <= 7'd0;
      end
    end
  end

  assign teamSwitch = (state_q == INN2) || (state_q == DONE);
  assign inningOver = (state_q == BREAK) || (state_q == DONE);
  assign gameOver   = (state_q == DONE);

  always_comb begin
    winner = WIN_NONE;
    if (state_q == DONE) begin
      if (team2Runs > team1Runs)      winner = WIN_TEAM2;
      else if (team1Runs > team2Runs) winner = WIN_TEAM1;
      else                            winner = WIN_TIE;
    end
  end

endmodule

// File: tb/tb_innings_sequencer.sv
// Randomized and directed bench for innings_sequencer against a match-level scoring model.
module tb_innings_sequencer;

  localparam int BALLS  = 12;
  localparam int WKTS   = 3;
  localparam int RUN_W  = 8;
  localparam int RUNMAX = (1 << RUN_W) - 1;
  localparam int M_INN1 = 0, M_BREAK = 1, M_INN2 = 2, M_DONE = 3;

  logic             clk_fpga = 1'b0;
  logic             reset;
  logic             bowl;
  logic [3:0]       lfsr_out;
  logic             delivery;
  logic [3:0]       outcome;
  logic             teamSwitch;
  logic             inningOver;
  logic             gameOver;
  logic [RUN_W-1:0] team1Runs;
  logic [RUN_W-1:0] team2Runs;
  logic [3:0]       wickets;
  logic [1:0]       winner;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_wk, m_balls, m_fh, m_out;
  int m_runs[2];
  int run_tab[16] = '{0, 0, 1, 1, 1, 2, 2, 3, 4, 4, 6, 0, 0, 1, 1, 0};

  innings_sequencer #(
    .BALLS_PER_INNING (BALLS),
    .WICKETS_PER_SIDE (WKTS),
    .RUN_W            (RUN_W)
  ) dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .bowl       (bowl),
    .lfsr_out   (lfsr_out),
    .delivery   (delivery),
    .outcome    (outcome),
    .teamSwitch (teamSwitch),
    .inningOver (inningOver),
    .gameOver   (gameOver),
    .team1Runs  (team1Runs),
    .team2Runs  (team2Runs),
    .wickets    (wickets),
    .winner     (winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_INN1; m_wk = 0; m_balls = 0; m_fh = 0; m_out = 0;
    m_runs[0] = 0; m_runs[1] = 0;
  endtask

  task automatic model_apply(input int code);
    int bat, wkt, legal, sum;
    bat   = (m_state == M_INN2) ? 1 : 0;
    wkt   = (code == 11 || code == 12) ? 1 : 0;
    legal = (code == 13 || code == 14) ? 0 : 1;
`ifdef FREE_HIT_EN
    if (m_fh != 0) wkt = 0;
    if (code == 14)     m_fh = 1;
    else if (legal != 0) m_fh = 0;
`endif
    sum = m_runs[bat] + run_tab[code];
    m_runs[bat] = (sum > RUNMAX) ? RUNMAX : sum;
    m_wk = (m_wk + wkt > WKTS) ? WKTS : m_wk + wkt;
    m_balls += legal;
    if (m_balls == BALLS || m_wk == WKTS || (bat == 1 && m_runs[1] > m_runs[0])) begin
      m_state = (bat == 1) ? M_DONE : M_BREAK;
      m_fh = 0;
    end
  endtask

  function automatic int exp_winner();
    if (m_state != M_DONE)      return 0;
    if (m_runs[1] > m_runs[0])  return 2;
    if (m_runs[0] > m_runs[1])  return 1;
    return 3;
  endfunction

  task automatic check_state();
    check("outcome",    outcome,    m_out);
    check("team1Runs",  team1Runs,  m_runs[0]);
    check("team2Runs",  team2Runs,  m_runs[1]);
    check("wickets",    wickets,    m_wk);
    check("teamSwitch", teamSwitch, (m_state == M_INN2 || m_state == M_DONE) ? 1 : 0);
    check("inningOver", inningOver, (m_state == M_BREAK || m_state == M_DONE) ? 1 : 0);
    check("gameOver",   gameOver,   (m_state == M_DONE) ? 1 : 0);
    check("winner",     winner,     exp_winner());
  endtask

  task automatic do_reset();
    reset = 1'b1; bowl = 1'b0; lfsr_out = 4'd0;
    repeat (2) @(negedge clk_fpga);
    reset = 1'b0;
    model_reset();
    @(negedge clk_fpga);
    check("reset_delivery", delivery, 0);
    check_state();
  endtask

  // One complete button press: edge, optional pulse, counter update, release.
  task automatic press(input int code);
    int issue;
    issue = (m_state == M_INN1 || m_state == M_INN2) ? 1 : 0;
    lfsr_out = 4'(code);
    bowl = 1'b1;
    repeat (3) @(negedge clk_fpga);
    check("delivery_issue", delivery, issue);
    if (issue != 0) begin
      m_out = code;
      check("outcome_issue", outcome, m_out);
      model_apply(code);
    end else if (m_state == M_BREAK) begin
      m_state = M_INN2; m_wk = 0; m_balls = 0; m_fh = 0;
    end
    lfsr_out = ~4'(code);
    @(negedge clk_fpga);
    check("delivery_end", delivery, 0);
    check_state();
    bowl = 1'b0;
    repeat (3) @(negedge clk_fpga);
    check("delivery_idle", delivery, 0);
  endtask

  initial begin
    reset = 1'b1; bowl = 1'b0; lfsr_out = 4'd0;
    model_reset();

    // Six on the first ball
    do_reset();
    press(10);
    check("t1_team1Runs", team1Runs, 6);

    // Extras do not count as balls; twelve legal balls still end the innings
    press(13);
    press(14);
    check("t2_team1Runs", team1Runs, 8);
    repeat (10) press(0);
    check("t2_not_over", inningOver, 0);
    press(0);
    check("t2_over", inningOver, 1);

    // Three wickets, then the break press switches sides without a delivery
    do_reset();
    repeat (3) press(11);
    check("t3_wickets", wickets, 3);
    check("t3_inningOver", inningOver, 1);
    check("t3_teamSwitch", teamSwitch, 0);
    press(0);
    check("t3_switch", teamSwitch, 1);
    check("t3_resumed", inningOver, 0);
    check("t3_wk_clear", wickets, 0);

    // A wide wins the chase
    do_reset();
    press(8); press(2);
    repeat (3) press(11);
    press(0);
    press(8); press(2);
    check("t4_level", team2Runs, 5);
    press(13);
    check("t4_team2Runs", team2Runs, 6);
    check("t4_gameOver", gameOver, 1);
    check("t4_winner", winner, 2);
    press(5);

    // Tie after both full innings
    do_reset();
    repeat (12) press(0);
    press(0);
    repeat (12) press(0);
    check("t5_winner", winner, 3);

    // Reset landing on the delivery cycle cancels the update
    do_reset();
    lfsr_out = 4'd10; bowl = 1'b1;
    repeat (3) @(negedge clk_fpga);
    check("t5_pulse", delivery, 1);
    reset = 1'b1; bowl = 1'b0;
    @(negedge clk_fpga);
    model_reset();
    check("t5_rst_delivery", delivery, 0);
    check_state();
    reset = 1'b0;
    repeat (3) @(negedge clk_fpga);
    check("t5_rst_hold", team1Runs, 0);

    // No-ball followed by a wicket code
    do_reset();
    press(14);
    press(11);
`ifdef FREE_HIT_EN
    check("t6_wickets", wickets, 0);
`else
    check("t6_wickets", wickets, 1);
`endif

    // Random matches
    for (int g = 0; g < 5; g++) begin
      do_reset();
      for (int p = 0; p < 70 && m_state != M_DONE; p++) press(int'($urandom_range(0, 15)));
      press(int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
